// File: rtl/acc_alu.sv
`default_nettype none
// ============================================================================
// Module   : acc_alu
// Purpose  : WIDTH-bit accumulator ALU with single-cycle ops and a shift-add MUL.
//            Define ACC_SAT_EN to saturate results instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module acc_alu #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             cmd_valid,
    input  logic [2:0]       op,
    input  logic             AB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] Z,
    output logic             carry,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

`ifdef ACC_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_INC  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       z_q, z_d;
    logic                   carry_q, carry_d;
    logic                   done_q, done_d;
    logic [WIDTH-1:0]       mcand_q, mcand_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic [2*WIDTH-1:0]     prod_q, prod_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [WIDTH-1:0]       w_d;
    logic [WIDTH:0]         w_add, w_sub, w_inc;
    logic [2*WIDTH-1:0]     w_prod_next;
    logic                   w_mul_ovf;

    assign w_d   = AB ? B : A;
    assign w_add = {1'b0, z_q} + {1'b0, w_d};
    assign w_sub = {1'b0, z_q} - {1'b0, w_d};
    assign w_inc = {1'b0, z_q} + (WIDTH+1)'(1);

    // One multiplier bit per cycle; the multiplier register shifts right so bit 0 is current.
    assign w_prod_next = prod_q + (mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q)
                                               : {2*WIDTH{1'b0}});
    assign w_mul_ovf   = |w_prod_next[2*WIDTH-1:WIDTH];

    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] val,
                                               input logic             ovf,
                                               input logic [WIDTH-1:0] sat_val);
        return (SAT_EN && ovf) ? sat_val : val;
    endfunction

    always_comb begin
        state_d  = state_q;
        z_d      = z_q;
        carry_d  = carry_q;
        done_d   = 1'b0;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    done_d = 1'b1;
                    case (op)
                        OP_NOP:  ;
                        OP_LOAD: begin z_d = w_d; carry_d = 1'b0; end
                        OP_INC:  begin
                            carry_d = w_inc[WIDTH];
                            z_d     = clamp(w_inc[WIDTH-1:0], w_inc[WIDTH], '1);
                        end
                        OP_DEC:  begin
                            carry_d = (z_q == '0);
                            z_d     = clamp(z_q - WIDTH'(1), z_q == '0, '0);
                        end
                        OP_ADD:  begin
                            carry_d = w_add[WIDTH];
                            z_d     = clamp(w_add[WIDTH-1:0], w_add[WIDTH], '1);
                        end
                        OP_SUB:  begin
                            carry_d = w_sub[WIDTH];
                            z_d     = clamp(w_sub[WIDTH-1:0], w_sub[WIDTH], '0);
                        end
                        OP_MUL:  begin
                            state_d  = S_MUL;
                            mcand_d  = z_q;
                            mplier_d = w_d;
                            prod_d   = '0;
                            cnt_d    = '0;
                            done_d   = 1'b0;
                        end
                        OP_CLR:  begin z_d = RESET_VAL; carry_d = 1'b0; end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                prod_d   = w_prod_next;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    z_d     = clamp(w_prod_next[WIDTH-1:0], w_mul_ovf, '1);
                    carry_d = w_mul_ovf;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q  <= S_IDLE;
            z_q      <= RESET_VAL;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            z_q      <= z_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ready = (state_q == S_IDLE);
    assign done  = done_q;
    assign Z     = z_q;
    assign carry = carry_q;
    assign zero  = (z_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_acc_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_alu
// Purpose  : Scoreboard bench for acc_alu (WIDTH=4, RESET_VAL=0), directed + random.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acc_alu;

    localparam int WIDTH = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;
`ifdef ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             clear = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [2:0]       op = 3'd0;
    logic             AB = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic             ready, done, carry, zero;
    logic [WIDTH-1:0] Z;

    acc_alu #(.WIDTH(WIDTH), .RESET_VAL('0)) dut (
        .clk(clk), .clear(clear), .cmd_valid(cmd_valid), .op(op), .AB(AB),
        .A(A), .B(B), .ready(ready), .done(done), .Z(Z), .carry(carry), .zero(zero)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int m_z = 0;
    int m_c = 0;
    int exp_z[$];
    int exp_c[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, then wrap or clamp.
    function automatic void model_step(input int opc, input int d);
        int r;
        case (opc)
            1: begin m_z = d; m_c = 0; end
            2, 4, 6: begin
                r = (opc == 2) ? m_z + 1 : (opc == 4) ? m_z + d : m_z * d;
                m_c = (r > MAXV) ? 1 : 0;
                m_z = (r > MAXV) ? (SAT ? MAXV : r % (MAXV + 1)) : r;
            end
            3, 5: begin
                r = (opc == 3) ? m_z - 1 : m_z - d;
                m_c = (r < 0) ? 1 : 0;
                m_z = (r < 0) ? (SAT ? 0 : r + MAXV + 1) : r;
            end
            7: begin m_z = 0; m_c = 0; end
            default: ;
        endcase
        exp_z.push_back(m_z);
        exp_c.push_back(m_c);
    endfunction

    always @(negedge clk) begin
        int ez, ec;
        if (done === 1'b1) begin
            if (exp_z.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL done_unexpected actual=1 expected=0 at %0t", $time);
            end else begin
                ez = exp_z.pop_front();
                ec = exp_c.pop_front();
                chk("z", int'(Z), ez);
                chk("carry", int'(carry), ec);
                chk("zero", int'(zero), (ez == 0) ? 1 : 0);
            end
        end
    end

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        exp_z.delete();
        exp_c.delete();
        m_z = 0;
        m_c = 0;
        @(negedge clk);
        chk("rst_z", int'(Z), 0);
        chk("rst_zero", int'(zero), 1);
        chk("rst_carry", int'(carry), 0);
        chk("rst_ready", int'(ready), 1);
        chk("rst_done", int'(done), 0);
    endtask

    task automatic issue(input int opc, input bit ab, input int a, input int b);
        int n = 0;
        while (ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=%0d expected=1", int'(ready));
        end else begin
            op = 3'(opc);
            AB = ab;
            A = WIDTH'(a);
            B = WIDTH'(b);
            cmd_valid = 1'b1;
            model_step(opc, ab ? b : a);
            @(negedge clk);
            cmd_valid = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_clear();

        issue(1, 1'b0, 9, 3);
        issue(4, 1'b1, 2, 9);
        issue(1, 1'b0, 15, 0);
        issue(2, 1'b0, 0, 0);
        issue(3, 1'b0, 0, 0);
        issue(0, 1'b0, 5, 5);

        // MUL 3*5: busy for WIDTH cycles, Z held, stray LOADs ignored.
        issue(1, 1'b0, 3, 0);
        issue(6, 1'b1, 0, 5);
        for (int k = 0; k < WIDTH; k++) begin
            chk("mul_busy_ready", int'(ready), 0);
            chk("mul_hold_z", int'(Z), 3);
            op = 3'd1;
            AB = 1'b0;
            A = 4'd12;
            cmd_valid = 1'b1;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        chk("mul_ready_back", int'(ready), 1);

        issue(1, 1'b0, 6, 0);
        issue(6, 1'b0, 6, 1);
        issue(1, 1'b1, 0, 3);
        issue(5, 1'b1, 0, 5);
        issue(7, 1'b0, 0, 0);

        // Abort MUL on its second cycle.
        issue(1, 1'b0, 2, 0);
        issue(6, 1'b1, 0, 7);
        @(negedge clk);
        do_clear();

        for (int i = 0; i < 400; i++) begin
            int opv;
            if ($urandom_range(0, 99) == 0) begin
                cmd_valid = 1'b0;
                do_clear();
            end else begin
                opv = int'($urandom_range(0, 7));
                op = 3'(opv);
                AB = 1'($urandom_range(0, 1));
                A = WIDTH'($urandom_range(0, MAXV));
                B = WIDTH'($urandom_range(0, MAXV));
                cmd_valid = ($urandom_range(0, 3) != 0);
                if (cmd_valid && ready === 1'b1)
                    model_step(opv, AB ? int'(B) : int'(A));
                @(negedge clk);
            end
        end
        cmd_valid = 1'b0;

        repeat (WIDTH + 3) @(negedge clk);
        chk("queue_empty", exp_z.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/acc_alu.md
Name: acc_alu

Overview:
- Parametrised successor to the 4-bit clear/load/inc accumulator.
- Holds a WIDTH-bit accumulator Z and selects operand D from input A or B.
- Executes single-cycle LOAD/INC/DEC/ADD/SUB/CLR and a multi-cycle shift-add MUL, with a valid/ready command handshake, a done pulse and carry/zero flags.
- Sits in the TRISC datapath as the accumulator register and is driven by the controller.

Parameters:
- WIDTH, 4, datapath width of A, B, D and Z (>=2).
- RESET_VAL, 0, value loaded into Z by clear and by the CLR op.

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  synchronous active-high reset.
- cmd_valid  input  1  command present this cycle.
- op  input  3  operation code, see Behaviour.
- AB  input  1  operand select: 0 selects A, 1 selects B.
- A  input  WIDTH  data input A.
- B  input  WIDTH  data input B.
- ready  output  1  high when a command can be accepted.
- done  output  1  one-cycle pulse after a command completes.
- Z  output  WIDTH  accumulator value.
- carry  output  1  carry/borrow/overflow flag of the last completed op.
- zero  output  1  combinational, high when Z == 0.

Behaviour:
- clear=1 at an edge: Z=RESET_VAL, carry=0, done=0, state=IDLE, so ready=1. clear overrides every other input, including a MUL in flight.
- D = AB ? B : A (combinational). A command is accepted when cmd_valid && ready at a rising edge. cmd_valid while ready=0 is ignored; commands are not queued.
- op codes and results, all arithmetic modulo 2^WIDTH unless the optional feature is enabled:
  - 000 NOP: Z and carry hold; still counts as accepted, so done pulses.
  - 001 LOAD: Z=D, carry=0.
  - 010 INC: Z=Z+1, carry=1 iff the old Z was all ones.
  - 011 DEC: Z=Z-1, carry=1 iff the old Z was 0.
  - 100 ADD: Z=Z+D, carry=carry-out.
  - 101 SUB: Z=Z-D, carry=borrow (old Z < D, unsigned).
  - 110 MUL: Z = low WIDTH bits of Z*D (unsigned); carry=1 iff the high WIDTH bits are nonzero.
  - 111 CLR: Z=RESET_VAL, carry=0.
- Single-cycle ops: Z and carry update at the accept edge; done=1 for exactly the next cycle; ready stays 1, so back-to-back commands are allowed every cycle.
- MUL state machine with two states, IDLE and MUL:
  - Accept edge: go IDLE->MUL; capture multiplicand=Z and multiplier=D; product=0; bit counter=0.
  - In MUL, ready=0. Each cycle processes one multiplier bit, LSB first: if the bit is set, product += multiplicand << counter; counter increments.
  - On the WIDTH-th MUL cycle edge: Z and carry are written, state returns to IDLE, done=1 for the following cycle.
  - Z therefore updates exactly WIDTH edges after the accept edge. Z is unchanged during MUL.
  - The product register is 2*WIDTH bits; the counter is clog2(WIDTH+1) bits.
- done is registered; it never asserts on the clear edge or on an aborted MUL.
- zero tracks Z combinationally: 1 after reset when RESET_VAL=0.

Optional Feature:
- Macro ACC_SAT_EN.
- When defined, ADD and INC clamp Z to all-ones on carry-out, and SUB and DEC clamp Z to 0 on borrow.
- MUL clamps Z to all-ones when the high half is nonzero.
- carry reports the same condition as in wrap mode.
- When undefined, all ops wrap modulo 2^WIDTH as listed above.

Test Plan (WIDTH=4, RESET_VAL=0):
- Reset: clear=1 for 1 cycle -> Z=0, zero=1, carry=0, ready=1, done=0.
- LOAD then ADD: LOAD AB=0 A=9 -> Z=9, done pulse. Then ADD AB=1 B=9 -> Z=2, carry=1 (with ACC_SAT_EN: Z=F, carry=1).
- INC then DEC: INC from Z=F -> Z=0, carry=1, zero=1. Then DEC from 0 -> Z=F, carry=1 (with ACC_SAT_EN: Z=0).
- MUL without overflow: Z=3, D=5 -> ready=0 for 4 cycles; Z=F at the 4th edge; carry=0; done pulse next cycle.
- MUL with overflow: Z=6, D=6 -> Z=4, carry=1 (with ACC_SAT_EN: Z=F).
- MUL abort and busy rules: cmd_valid LOAD during MUL is ignored and Z is unchanged. clear asserted on the 2nd MUL cycle -> Z=0, no done pulse, ready=1 the next cycle.
- SUB underflow: Z=3, SUB D=5 -> Z=E, carry=1 (with ACC_SAT_EN: Z=0, zero=1).
